// File: rtl/or_pkg.sv
// Shared reduction-mode encodings for the OR-reduce pipeline and its bench.
package or_pkg;
    typedef enum logic [1:0] {
        MODE_OR  = 2'b00,
        MODE_NOR = 2'b01,
        MODE_AND = 2'b10,
        MODE_XOR = 2'b11
    } mode_e;
endpackage

// File: rtl/or_reduce_core.sv
// Combinational WIDTH-bit reduction, selected by mode.
module or_reduce_core
    import or_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    input  logic [1:0]       mode,
    output logic             result
);
    always_comb begin
        result = 1'b0;
        case (mode_e'(mode))
            MODE_OR:  result = |data;
            MODE_NOR: result = ~(|data);
            MODE_AND: result = &data;
            MODE_XOR: result = ^data;
            default:  result = 1'b0;
        endcase
    end
endmodule

// File: rtl/or_reduce_pipe.sv
// Two-stage registered reduction with a sticky hit flag and saturating hit counter.
module or_reduce_pipe
    import or_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       mode,
    input  logic             acc_clr,
    output logic             out_valid,
    output logic             out,
    output logic             acc_out,
    output logic [CNT_W-1:0] hit_cnt
);
    logic [WIDTH-1:0] s1_data;
    logic [1:0]       s1_mode;
    logic [1:0]       vld_pipe;
    logic             s1_valid;
    logic             red;
    logic             hit;

    assign s1_valid  = vld_pipe[0];
    assign out_valid = vld_pipe[1];

    or_reduce_core #(.WIDTH(WIDTH)) u_core (
        .data   (s1_data),
        .mode   (s1_mode),
        .result (red)
    );

    assign hit = s1_valid & red;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_data  <= '0;
            s1_mode  <= MODE_OR;
            vld_pipe <= '0;
            out      <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[0], in_valid};
            if (in_valid) begin
                s1_data <= in_data;
                s1_mode <= mode;
            end
            if (s1_valid) out <= red;
        end
    end

    // Clear takes priority over a coincident hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_out <= 1'b0;
            hit_cnt <= '0;
        end else if (acc_clr) begin
            acc_out <= 1'b0;
            hit_cnt <= '0;
        end else if (hit) begin
            acc_out <= 1'b1;
            if (hit_cnt != {CNT_W{1'b1}}) hit_cnt <= hit_cnt + 1'b1;
        end
    end
endmodule

// File: doc/or_reduce_pipe.md
OR_REDUCE_PIPE -- requirements
Module: or_reduce_pipe

Interface
REQ-001 Parameter WIDTH, default 8, number of reduced input bits; legal range 2..64.
REQ-002 Parameter CNT_W, default 16, width of the hit counter; legal range 4..32.
REQ-003 Port clk, input, 1: single clock; all flops on rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port in_valid, input, 1: in_data and mode are valid this cycle.
REQ-006 Port in_data, input, WIDTH: operand vector to reduce.
REQ-007 Port mode, input, 2: reduction select; 00 OR, 01 NOR, 10 AND, 11 XOR.
REQ-008 Port acc_clr, input, 1: synchronous clear of acc_out and hit_cnt.
REQ-009 Port out_valid, output, 1: out carries a new result this cycle.
REQ-010 Port out, output, 1: registered reduction result.
REQ-011 Port acc_out, output, 1: sticky OR of all valid results since the last clear or reset.
REQ-012 Port hit_cnt, output, CNT_W: count of valid results equal to 1; saturating.

Function
REQ-013 Stage 1 shall register in_data and mode on every edge where in_valid=1, and hold them otherwise; s1_valid shall register in_valid every edge.
REQ-014 Stage 2 shall compute the reduction of the stage-1 data per the stage-1 mode, register it into out when s1_valid=1, and hold out otherwise.
REQ-015 out_valid shall equal s1_valid delayed one edge; latency from in_valid sampled to out_valid high shall be exactly 2 clocks.
REQ-016 Back-to-back in_valid shall yield one result per clock with no bubbles; throughput 1/clock.
REQ-017 Each result shall use the mode sampled together with its data; a mode change between beats shall not affect in-flight beats.
REQ-018 acc_out shall be set on the same edge that writes out=1 with s1_valid=1, and shall remain set until acc_clr or reset.
REQ-019 hit_cnt shall increment by 1 on each edge writing out=1 with s1_valid=1, and shall saturate at all-ones without wrapping.
REQ-020 acc_clr=1 shall zero acc_out and hit_cnt on that edge; if a hit occurs on the same edge, the clear wins (both read 0 afterwards).
REQ-021 acc_clr shall not affect out, out_valid or pipeline contents.
REQ-022 in_data all-zero: OR=0, NOR=1, AND=0, XOR=0; all-ones: OR=1, NOR=0, AND=1, XOR=WIDTH mod 2.

Reset
REQ-023 rst_n low shall immediately clear all flops: stage-1 data and mode to 0, s1_valid=0, out=0, out_valid=0, acc_out=0, hit_cnt=0.
REQ-024 Reset asserted mid-stream shall discard in-flight beats; no out_valid shall appear for beats accepted before reset.
REQ-025 Release of rst_n shall be treated as synchronous to clk; the first in_valid sampled after release shall produce out_valid 2 clocks later.

Structure
REQ-026 Mode encodings (MODE_OR, MODE_NOR, MODE_AND, MODE_XOR) shall live in a shared package, or_pkg, used by RTL and bench.
REQ-027 The reduction logic shall be a separate combinational sub-module, or_reduce_core (WIDTH-parameterised, inputs data and mode, output result); the pipeline, accumulator and counter stay in or_reduce_pipe.

Verification (WIDTH=8, CNT_W=16 unless stated)
REQ-028 Reset with in_valid=0 -> all outputs 0; assert rst_n low mid-stream with 2 beats in flight -> no out_valid after release.
REQ-029 Beats 8'h00 with mode 00/01/10/11 -> out 0/1/0/0; beats 8'hFF -> 1/0/1/0; 8'h07 XOR -> 1; each out_valid exactly 2 clocks after its beat.
REQ-030 Four back-to-back beats with mode alternating 00,10,00,10 and data 8'h01 -> out 1,0,1,0 on four consecutive out_valid cycles.
REQ-031 Results 0,0,1,0 -> acc_out rises with the third result and stays 1, hit_cnt=1; acc_clr on the same edge as a hit -> acc_out=0, hit_cnt=0.
REQ-032 CNT_W=4, 20 consecutive hits -> hit_cnt climbs to 4'hF and holds at 4'hF.
REQ-033 Random data/mode/in_valid for 1000 cycles -> out matches a reference reduction model delayed 2 clocks, and hit_cnt matches the model count.
